// File: rtl/mips_bus_pkg.sv
// Shared constants, types and address helper for the mips_cpu_bus memory responder.
package mips_bus_pkg;

    localparam logic [31:0] MIPS_RESET_VECTOR = 32'hBFC00000;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_BYTE1   = 4'b0010;
    localparam logic [3:0] BE_BYTE2   = 4'b0100;
    localparam logic [3:0] BE_BYTE3   = 4'b1000;

    typedef enum logic {
        IDLE,
        WAIT
    } resp_state_t;

    // Word index relative to the base; wraps modulo 2^32 so addresses below the
    // base land far out of range instead of aliasing onto low words.
    function automatic logic [31:0] addr_to_index(input logic [31:0] address,
                                                  input logic [31:0] base);
        logic [31:0] offset;
        offset = address - base;
        return offset >> 2;
    endfunction

endpackage

// File: rtl/mips_bus_mem_responder_if.sv
// Request/response signals of the mips_cpu_bus data/instruction port.
interface mips_bus_mem_responder_if;

    logic [31:0] address;
    logic        write;
    logic        read;
    logic        waitrequest;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;

    modport master (
        output address, write, read, writedata, byteenable,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, write, read, writedata, byteenable,
        output waitrequest, readdata
    );

endinterface

// File: rtl/mips_bus_wait_ctrl.sv
// Wait-state sequencer: stalls every request for WAIT_CYCLES cycles, restarts the
// stall when the request changes, and pulses complete on the edge the access lands.
module mips_bus_wait_ctrl
    import mips_bus_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] address,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic        waitrequest,
    output logic        complete
);

    localparam logic [3:0] WAIT_LIMIT = 4'(WAIT_CYCLES);

    resp_state_t state;
    resp_state_t state_next;
    logic [3:0]  count;
    logic [3:0]  count_next;
    logic [69:0] req_now;
    logic [69:0] req_prev;
    logic        req;
    logic        req_changed;

    assign req         = read | write;
    assign req_now     = {address, writedata, byteenable, read, write};
    assign req_changed = (req_now != req_prev);

    // State, stall counter and last-cycle copy of the request lines.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= 4'd0;
            req_prev <= '0;
        end else begin
            state    <= state_next;
            count    <= count_next;
            req_prev <= req_now;
        end
    end

    // Next state, counter and stall/complete decode; reset suppresses both outputs
    // so a request in flight is dropped without touching memory.
    always_comb begin
        state_next  = state;
        count_next  = count;
        waitrequest = 1'b0;
        complete    = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (req) begin
                        if (WAIT_CYCLES == 0) begin
                            complete = 1'b1;
                        end else begin
                            waitrequest = 1'b1;
                            count_next  = 4'd1;
                            state_next  = WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!req) begin
                        count_next = 4'd0;
                        state_next = IDLE;
                    end else if (req_changed) begin
                        waitrequest = 1'b1;
                        count_next  = 4'd1;
                    end else if (count != WAIT_LIMIT) begin
                        waitrequest = 1'b1;
                        count_next  = count + 4'd1;
                    end else begin
                        complete   = 1'b1;
                        count_next = 4'd0;
                        state_next = IDLE;
                    end
                end
                default: begin
                    count_next = 4'd0;
                    state_next = IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/mips_bus_mem_responder.sv
// Word-organised RAM answering mips_cpu_bus requests: byte-lane writes, registered
// reads, range/alignment checks and a sticky error flag. The array has no reset and
// powers up undefined; INIT_FILE names the image for an external preload flow.
module mips_bus_mem_responder
    import mips_bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = MIPS_RESET_VECTOR,
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter string       INIT_FILE   = "",
    localparam int         IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                    clk,
    input  logic                    reset,
    mips_bus_mem_responder_if.slave bus,
    output logic                    err,
    input  logic [IDX_W-1:0]        dbg_addr,
    output logic [31:0]             dbg_data
);

    logic [31:0]      mem [DEPTH_WORDS];
    logic [31:0]      word_index;
    logic [IDX_W-1:0] idx;
    logic             null_addr;
    logic             misaligned;
    logic             in_range;
    logic             addr_ok;
    logic             be_none;
    logic             complete;
    logic             do_write;
    logic             do_read;
    logic             access_err;
    logic [31:0]      write_word;
    logic [31:0]      readdata_q;
    logic             err_q;

    mips_bus_wait_ctrl #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_ctrl (
        .clk         (clk),
        .reset       (reset),
        .read        (bus.read),
        .write       (bus.write),
        .address     (bus.address),
        .writedata   (bus.writedata),
        .byteenable  (bus.byteenable),
        .waitrequest (bus.waitrequest),
        .complete    (complete)
    );

    assign word_index = addr_to_index(bus.address, BASE_ADDR);
    assign idx        = word_index[IDX_W-1:0];
    assign null_addr  = (bus.address == 32'd0);
    assign misaligned = (bus.address[1:0] != 2'b00);
    assign in_range   = (word_index < 32'(DEPTH_WORDS));
    assign addr_ok    = in_range && !misaligned && !null_addr;
    assign be_none    = (bus.byteenable == 4'b0000);

    // A simultaneous read+write is treated as a write; the read half is dropped.
    assign do_write   = complete && bus.write && addr_ok && !be_none;
    assign do_read    = complete && bus.read && !bus.write;
    assign access_err = complete && ((!addr_ok && !null_addr)
                                     || (bus.write && be_none)
                                     || (bus.read && bus.write));

    assign bus.readdata = readdata_q;
    assign err          = err_q;
    assign dbg_data     = mem[dbg_addr];

    // Merge the enabled byte lanes of writedata into the currently stored word.
    always_comb begin
        write_word = mem[idx];
        for (int i = 0; i < 4; i++) begin
            if ((bus.byteenable & (BE_BYTE0 << i)) != 4'b0000) begin
                write_word[8*i +: 8] = bus.writedata[8*i +: 8];
            end
        end
    end

    // Commit the merged word on the completion edge.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[idx] <= write_word;
        end
    end

    // Registered read data and sticky error; bad or null reads return zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata_q <= 32'd0;
            err_q      <= 1'b0;
        end else begin
            if (do_read) begin
                readdata_q <= addr_ok ? mem[idx] : 32'd0;
            end
            if (access_err) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mips_bus_mem_responder.sv
// Bench for mips_bus_mem_responder: a zero-wait and a three-wait instance driven with
// directed and random accesses, checked against an array-based memory model.
module tb_mips_bus_mem_responder;
    import mips_bus_pkg::*;

    localparam logic [31:0] BASE  = MIPS_RESET_VECTOR;
    localparam int          DEPTH = 64;

    logic        clk;
    logic        reset;
    logic        err0, err3;
    logic [5:0]  dbg_addr0, dbg_addr3;
    logic [31:0] dbg_data0, dbg_data3;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] model_mem [2][DEPTH];
    logic [31:0] model_rd  [2];
    bit          model_err [2];

    mips_bus_mem_responder_if bus0 ();
    mips_bus_mem_responder_if bus3 ();

    mips_bus_mem_responder #(
        .BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .INIT_FILE("")
    ) dut0 (
        .clk(clk), .reset(reset), .bus(bus0), .err(err0),
        .dbg_addr(dbg_addr0), .dbg_data(dbg_data0)
    );

    mips_bus_mem_responder #(
        .BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(3), .INIT_FILE("")
    ) dut3 (
        .clk(clk), .reset(reset), .bus(bus3), .err(err3),
        .dbg_addr(dbg_addr3), .dbg_data(dbg_data3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wait_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic logic get_wait(input int d);
        return (d == 0) ? bus0.waitrequest : bus3.waitrequest;
    endfunction

    function automatic logic [31:0] get_rd(input int d);
        return (d == 0) ? bus0.readdata : bus3.readdata;
    endfunction

    function automatic logic get_err(input int d);
        return (d == 0) ? err0 : err3;
    endfunction

    task automatic drive_bus(input int d, input logic rd, input logic wr,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [3:0] be);
        if (d == 0) begin
            bus0.read = rd; bus0.write = wr; bus0.address = addr;
            bus0.writedata = wd; bus0.byteenable = be;
        end else begin
            bus3.read = rd; bus3.write = wr; bus3.address = addr;
            bus3.writedata = wd; bus3.byteenable = be;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Reference behaviour of one completed access, straight from the address map rules.
    task automatic model_access(input int d, input logic rd, input logic wr,
                                input logic [31:0] addr, input logic [31:0] wd,
                                input logic [3:0] be);
        logic [31:0] index;
        logic [31:0] mask;
        bit          zero;
        bit          ok;
        index = (addr - BASE) / 4;
        zero  = (addr == 32'd0);
        ok    = !zero && (addr % 4 == 0) && (index < DEPTH);
        if (!zero && !ok) model_err[d] = 1'b1;
        if (wr) begin
            if (be == 4'b0000 || rd) model_err[d] = 1'b1;
            if (ok) begin
                mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
                model_mem[d][index[5:0]] = (model_mem[d][index[5:0]] & ~mask) | (wd & mask);
            end
        end else if (rd) begin
            model_rd[d] = ok ? model_mem[d][index[5:0]] : 32'd0;
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            model_rd[d]  = 32'd0;
            model_err[d] = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        drive_bus(0, 0, 0, 0, 0, 0);
        drive_bus(1, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic check_word(input int d, input int index, input string tag);
        if (d == 0) dbg_addr0 = 6'(index); else dbg_addr3 = 6'(index);
        #1;
        checkOutput(tag, (d == 0) ? dbg_data0 : dbg_data3, model_mem[d][index]);
    endtask

    // Waits out the stall of the request already on the bus, then checks the result.
    task automatic finish_access(input int d, input logic rd, input logic wr,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 input logic [3:0] be, input string tag);
        int stalls;
        bit done;
        stalls = 0;
        done   = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            if (get_wait(d)) stalls++;
            else done = 1'b1;
            @(posedge clk); #1;
        end
        drive_bus(d, 0, 0, 0, 0, 0);
        checkOutput({tag, " completed"}, 32'(done), 32'd1);
        checkOutput({tag, " stalls"}, 32'(stalls), 32'(wait_of(d)));
        model_access(d, rd, wr, addr, wd, be);
        @(negedge clk);
        checkOutput({tag, " readdata"}, get_rd(d), model_rd[d]);
        checkOutput({tag, " err"}, 32'(get_err(d)), 32'(model_err[d]));
    endtask

    task automatic applyStimulus(input int d, input logic rd, input logic wr,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 input logic [3:0] be, input string tag);
        @(posedge clk); #1;
        drive_bus(d, rd, wr, addr, wd, be);
        finish_access(d, rd, wr, addr, wd, be, tag);
    endtask

    initial begin
        logic [31:0] data;
        logic [31:0] addr;
        logic [3:0]  be;
        logic        rd, wr;
        int          d, kind, idx;

        reset = 1'b1;
        dbg_addr0 = '0;
        dbg_addr3 = '0;
        drive_bus(0, 0, 0, 0, 0, 0);
        drive_bus(1, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checkOutput("reset readdata", get_rd(k), 32'd0);
            checkOutput("reset err", 32'(get_err(k)), 32'd0);
            checkOutput("reset waitrequest", 32'(get_wait(k)), 32'd0);
        end

        // Fill both memories so every later expectation starts from known data.
        for (int i = 0; i < DEPTH; i++) begin
            for (int k = 0; k < 2; k++) begin
                data = $urandom;
                applyStimulus(k, 0, 1, BASE + 32'(4 * i), data, BE_WORD, "fill");
            end
        end

        // Zero-wait write then read of the same word.
        applyStimulus(0, 0, 1, 32'hBFC00030, 32'hDEADBEEF, BE_WORD, "t1 write");
        applyStimulus(0, 1, 0, 32'hBFC00030, 32'h0, BE_WORD, "t1 read");
        checkOutput("t1 readdata const", get_rd(0), 32'hDEADBEEF);
        check_word(0, 12, "t1 dbg word12");

        // Three-wait read of word 1.
        applyStimulus(1, 0, 1, 32'hBFC00004, 32'h8D09002C, BE_WORD, "t2 write");
        applyStimulus(1, 1, 0, 32'hBFC00004, 32'h0, BE_WORD, "t2 read");
        checkOutput("t2 readdata const", get_rd(1), 32'h8D09002C);

        // Byte-lane merge and empty byte enable.
        applyStimulus(1, 0, 1, 32'hBFC00014, 32'h11223344, BE_WORD, "t3 seed");
        applyStimulus(1, 0, 1, 32'hBFC00014, 32'hAABBCCDD, 4'b0101, "t3 merge");
        check_word(1, 5, "t3 dbg merged");
        checkOutput("t3 merged const", dbg_data3, 32'h11BB33DD);
        applyStimulus(1, 0, 1, 32'hBFC00014, 32'h99999999, 4'b0000, "t3 be none");
        check_word(1, 5, "t3 dbg unchanged");
        checkOutput("t3 err const", 32'(err3), 32'd1);
        do_reset();

        // Null address, out-of-range read, and error stickiness.
        applyStimulus(0, 1, 0, 32'h00000000, 32'h0, BE_WORD, "t4 null read");
        applyStimulus(0, 1, 0, 32'hBFC00400, 32'h0, BE_WORD, "t4 range read");
        applyStimulus(0, 1, 0, 32'hBFC00030, 32'h0, BE_WORD, "t4 sticky read");
        repeat (3) @(negedge clk);
        checkOutput("t4 err held", 32'(err0), 32'd1);
        do_reset();
        checkOutput("t4 err cleared", 32'(err0), 32'd0);

        // Reset landing two stall cycles into a write abandons it.
        @(posedge clk); #1;
        drive_bus(1, 0, 1, BASE + 32'd8, 32'h5, BE_WORD);
        @(negedge clk);
        checkOutput("t5 stall 1", 32'(bus3.waitrequest), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("t5 stall 2", 32'(bus3.waitrequest), 32'd1);
        #1 reset = 1'b1;
        drive_bus(1, 0, 0, 0, 0, 0);
        #1 checkOutput("t5 wait in reset", 32'(bus3.waitrequest), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        check_word(1, 2, "t5 word2 kept");
        checkOutput("t5 err", 32'(err3), 32'd0);
        applyStimulus(1, 0, 1, BASE + 32'd8, 32'h5, BE_WORD, "t5 reissue");
        check_word(1, 2, "t5 word2 written");

        // Address change mid-stall restarts the stall and only the new word is written.
        data = $urandom;
        @(posedge clk); #1;
        drive_bus(1, 0, 1, BASE + 32'd4, data, BE_WORD);
        @(negedge clk);
        checkOutput("t6 first stall", 32'(bus3.waitrequest), 32'd1);
        @(posedge clk); #1;
        drive_bus(1, 0, 1, BASE + 32'd8, data, BE_WORD);
        finish_access(1, 0, 1, BASE + 32'd8, data, BE_WORD, "t6 changed");
        check_word(1, 1, "t6 word1 untouched");
        check_word(1, 2, "t6 word2 written");

        // Zero-wait back-to-back stream including read-after-write to one word.
        begin
            logic [31:0] seq_addr [6];
            logic        seq_rd   [6];
            logic        seq_wr   [6];
            logic [3:0]  seq_be   [6];
            seq_addr = '{BASE + 32'd40, BASE + 32'd40, BASE + 32'd40, BASE + 32'd40,
                         BASE + 32'd44, BASE + 32'd44};
            seq_rd   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
            seq_wr   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
            seq_be   = '{BE_WORD, BE_WORD, BE_HALF_HI, BE_HALF_LO, BE_BYTE2, BE_BYTE3};
            @(posedge clk); #1;
            for (int k = 0; k < 6; k++) begin
                data = $urandom;
                drive_bus(0, seq_rd[k], seq_wr[k], seq_addr[k], data, seq_be[k]);
                @(negedge clk);
                checkOutput("b2b waitrequest", 32'(bus0.waitrequest), 32'd0);
                if (k > 0) checkOutput("b2b readdata", bus0.readdata, model_rd[0]);
                @(posedge clk); #1;
                model_access(0, seq_rd[k], seq_wr[k], seq_addr[k], data, seq_be[k]);
            end
            drive_bus(0, 0, 0, 0, 0, 0);
            @(negedge clk);
            checkOutput("b2b last readdata", bus0.readdata, model_rd[0]);
            check_word(0, 11, "b2b word11");
        end

        // Random mix of legal and illegal accesses on both instances.
        for (int n = 0; n < 48; n++) begin
            if (n % 8 == 0) do_reset();
            d    = $urandom_range(0, 1);
            idx  = $urandom_range(0, DEPTH - 1);
            kind = $urandom_range(0, 9);
            case (kind)
                0:       addr = 32'h0;
                1:       addr = BASE + 32'(4 * (DEPTH + $urandom_range(0, 15)));
                2:       addr = BASE + 32'(4 * idx) + 32'($urandom_range(1, 3));
                3:       addr = BASE - 32'd4;
                default: addr = BASE + 32'(4 * idx);
            endcase
            kind = $urandom_range(0, 5);
            rd   = (kind <= 1) || (kind == 5);
            wr   = (kind >= 2);
            be   = 4'($urandom_range(0, 15));
            data = $urandom;
            applyStimulus(d, rd, wr, addr, data, be, "rand");
            check_word(d, idx, "rand dbg");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
